// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: a small byte FIFO drained by an 8N1 serialiser,
// with STATUS and baud-divisor registers on the CPU's word-addressed bus.
module mmio_uart_tx #(
    parameter logic [29:0] BASE        = 30'h3FFF_FFF0,
    parameter int          DEPTH       = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [29:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    output logic [31:0] rdata,
    output logic        txd,
    output logic        irq_empty
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_DIV    = 2'd2;

    logic        sel;
    logic [1:0]  offset;
    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, full, busy;
    logic        push_req, push, pop, ovf_set, ovf_clr;
    logic        overflow;
    logic [15:0] divisor;
    logic [31:0] reg_val;

    state_t      state, state_next;
    logic [15:0] bit_cnt, cnt_next;
    logic [15:0] bit_div, div_next;
    logic [2:0]  bit_idx, idx_next;
    logic [7:0]  shift_reg, shift_next;
    logic        txd_next;
    logic        bit_end;

    logic        unused_wdata;
    assign unused_wdata = ^wdata[31:16];

    assign sel    = (addr[29:2] == BASE[29:2]);
    assign offset = addr[1:0];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign busy  = (state != IDLE);

    // The serialiser pops whenever it is idle; a push while full survives only if that pop frees a slot.
    assign pop      = (state == IDLE) && !empty;
    assign push_req = we && sel && (offset == OFF_TXDATA);
    assign push     = push_req && (!full || pop);
    assign ovf_set  = push_req && full && !pop;
    assign ovf_clr  = we && sel && (offset == OFF_STATUS) && wdata[3];

    always_comb begin
        reg_val = 32'd0;
        case (offset)
            OFF_STATUS: reg_val = {28'd0, overflow, busy, full, empty};
            OFF_DIV:    reg_val = {16'd0, divisor};
            default:    reg_val = 32'd0;
        endcase
    end

    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            divisor   <= DEFAULT_DIV;
            rdata     <= 32'd0;
            irq_empty <= 1'b1;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (ovf_set)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
            if (we && sel && (offset == OFF_DIV))
                divisor <= (wdata[15:0] == 16'd0) ? 16'd1 : wdata[15:0];
            rdata     <= (re && sel) ? reg_val : 32'd0;
            irq_empty <= empty && !busy;
        end
    end

    // NOTE: the FIFO storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= wdata[7:0];
    end

    assign bit_end = (bit_cnt == bit_div - 16'd1);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = bit_cnt;
        div_next   = bit_div;
        idx_next   = bit_idx;
        shift_next = shift_reg;
        txd_next   = txd;
        case (state)
            IDLE: begin
                txd_next = 1'b1;
                if (!empty) begin
                    state_next = START;
                    shift_next = mem[rd_ptr[AW-1:0]];
                    div_next   = divisor;
                    cnt_next   = 16'd0;
                    txd_next   = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                    cnt_next   = 16'd0;
                    idx_next   = 3'd0;
                    txd_next   = shift_reg[0];
                    shift_next = {1'b0, shift_reg[7:1]};
                end else begin
                    cnt_next = bit_cnt + 16'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_next = 16'd0;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                        txd_next   = 1'b1;
                    end else begin
                        idx_next   = bit_idx + 3'd1;
                        txd_next   = shift_reg[0];
                        shift_next = {1'b0, shift_reg[7:1]};
                    end
                end else begin
                    cnt_next = bit_cnt + 16'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_next = IDLE;
                    cnt_next   = 16'd0;
                end else begin
                    cnt_next = bit_cnt + 16'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= 16'd0;
            bit_div   <= DEFAULT_DIV;
            bit_idx   <= 3'd0;
            shift_reg <= 8'd0;
            txd       <= 1'b1;
        end else begin
            state     <= state_next;
            bit_cnt   <= cnt_next;
            bit_div   <= div_next;
            bit_idx   <= idx_next;
            shift_reg <= shift_next;
            txd       <= txd_next;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register access, frame timing, FIFO overflow,
// push-on-pop, address decode, and mid-frame reset.
module tb_mmio_uart_tx;

    localparam logic [29:0] BASE       = 30'h3FFF_FFF0;
    localparam logic [29:0] A_TXDATA   = BASE;
    localparam logic [29:0] A_STATUS   = BASE + 30'd1;
    localparam logic [29:0] A_DIV      = BASE + 30'd2;
    localparam logic [29:0] A_OUTSIDE  = BASE + 30'd4;
    localparam logic [29:0] A_OUTSIDE1 = BASE + 30'd5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [31:0] rdata;
    logic        txd;
    logic        irq_empty;

    int checks = 0;
    int errors = 0;

    logic [7:0] rx_q[$];
    bit         mon_en  = 1'b0;
    int         cur_div = 2;

    // start bit, A5 LSB-first, stop bit (index 0 goes out first)
    logic [9:0] a5_frame = 10'b1_1010_0101_0;

    mmio_uart_tx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .addr      (addr),
        .wdata     (wdata),
        .we        (we),
        .re        (re),
        .rdata     (rdata),
        .txd       (txd),
        .irq_empty (irq_empty)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus tasks start and end on a negedge so consecutive calls hit consecutive posedges.
    task automatic wr(input logic [29:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd(input logic [29:0] a, output logic [31:0] v);
        addr = a;
        re   = 1'b1;
        @(negedge clk);
        re = 1'b0;
        v  = rdata;
    endtask

    task automatic wait_rx(input int n, input int budget);
        int cyc;
        cyc = 0;
        while (rx_q.size() < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check("rx_count", rx_q.size(), n);
    endtask

    // Frame receiver: samples one point per bit period on negedges.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && txd === 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (cur_div) @(negedge clk);
                    b[i] = txd;
                end
                repeat (cur_div) @(negedge clk);
                check("stop_bit", {31'd0, txd}, 32'd1);
                rx_q.push_back(b);
            end
        end
    end

    initial begin
        logic [31:0] v;
        int          lows;

        rst_n = 1'b0;
        addr  = '0;
        wdata = '0;
        we    = 1'b0;
        re    = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_rdata", rdata, 32'd0);
        check("rst_txd", {31'd0, txd}, 32'd1);
        check("rst_irq", {31'd0, irq_empty}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        rd(A_STATUS, v);
        check("status_after_reset", v, 32'h1);
        rd(A_DIV, v);
        check("div_after_reset", v, 32'd434);
        check("idle_txd", {31'd0, txd}, 32'd1);
        check("idle_irq", {31'd0, irq_empty}, 32'd1);
        @(negedge clk);
        check("rdata_no_read", rdata, 32'd0);

        // single A5 frame, divisor 4
        wr(A_DIV, 32'd4);
        wr(A_TXDATA, 32'hA5);
        check("a5_before_start", {31'd0, txd}, 32'd1);
        for (int k = 0; k < 40; k++) begin
            int j;
            @(negedge clk);
            j = k / 4;
            check($sformatf("a5_frame_k%0d", k), {31'd0, txd}, {31'd0, a5_frame[j]});
        end
        repeat (3) @(negedge clk);
        check("a5_done_irq", {31'd0, irq_empty}, 32'd1);
        rd(A_STATUS, v);
        check("a5_done_status", v, 32'h1);

        // back-to-back writes, overflow on the sixth, clear via STATUS
        cur_div = 2;
        mon_en  = 1'b1;
        wr(A_DIV, 32'd2);
        for (int i = 1; i <= 6; i++)
            wr(A_TXDATA, i);
        rd(A_STATUS, v);
        check("status_overflow", v, 32'hE);
        check("irq_while_busy", {31'd0, irq_empty}, 32'd0);
        wr(A_STATUS, 32'h8);
        rd(A_STATUS, v);
        check("status_ovf_cleared", v, 32'h6);
        wait_rx(5, 400);
        for (int i = 0; i < 5 && i < rx_q.size(); i++)
            check($sformatf("b2b_byte%0d", i), {24'd0, rx_q[i]}, i + 1);
        repeat (4) @(negedge clk);
        rd(A_STATUS, v);
        check("b2b_drained_status", v, 32'h1);
        check("b2b_drained_irq", {31'd0, irq_empty}, 32'd1);

        // fill the FIFO, then push on exactly the edge the idle FSM pops
        rx_q.delete();
        for (int i = 0; i < 5; i++)
            wr(A_TXDATA, 32'h11 + i);
        repeat (17) @(negedge clk);
        wr(A_TXDATA, 32'h16);
        rd(A_STATUS, v);
        check("push_on_pop_status", v, 32'h6);
        wait_rx(6, 800);
        for (int i = 0; i < 6 && i < rx_q.size(); i++)
            check($sformatf("pop_push_byte%0d", i), {24'd0, rx_q[i]}, 32'h11 + i);
        repeat (4) @(negedge clk);

        // outside the window, DIV=0 clamp, simultaneous read/write
        rx_q.delete();
        wr(A_OUTSIDE, 32'h77);
        rd(A_OUTSIDE, v);
        check("outside_rd", v, 32'd0);
        rd(A_OUTSIDE1, v);
        check("outside1_rd", v, 32'd0);
        rd(A_STATUS, v);
        check("outside_no_push", v, 32'h1);
        repeat (50) @(negedge clk);
        check("outside_no_frame", rx_q.size(), 32'd0);
        wr(A_DIV, 32'd0);
        rd(A_DIV, v);
        check("div_zero_clamp", v, 32'd1);
        addr  = A_DIV;
        wdata = 32'd5;
        we    = 1'b1;
        re    = 1'b1;
        @(negedge clk);
        we = 1'b0;
        re = 1'b0;
        check("rw_same_cycle_old", rdata, 32'd1);
        rd(A_DIV, v);
        check("rw_same_cycle_new", v, 32'd5);

        // reset in the middle of the DATA bits of a 3C frame
        mon_en = 1'b0;
        wr(A_DIV, 32'd4);
        wr(A_TXDATA, 32'h3C);
        repeat (7) @(negedge clk);
        check("pre_reset_data_low", {31'd0, txd}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("reset_txd_immediate", {31'd0, txd}, 32'd1);
        check("reset_irq_immediate", {31'd0, irq_empty}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd(A_STATUS, v);
        check("post_reset_status", v, 32'h1);
        rd(A_DIV, v);
        check("post_reset_div", v, 32'd434);
        lows = 0;
        repeat (200) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        check("post_reset_no_frame", lows, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
